// File: rtl/turbo_stream_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turbo_stream_receiver_pkg
// Description : Shared constants, FSM encoding and RSC polynomials for the
//               turbo stream receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package turbo_stream_receiver_pkg;

  localparam int K_LONG      = 6144;
  localparam int K_SHORT     = 1056;
  localparam int TAIL_CYCLES = 4;
  localparam int CNT_W       = 13;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  // Bit i of each polynomial is the D^i coefficient.
  localparam logic [3:0] RSC_G0 = 4'b1101;  // feedback 1 + D^2 + D^3
  localparam logic [3:0] RSC_G1 = 4'b1011;  // parity   1 + D + D^3

  // Index i holds the D^i delay element (s1..s3).
  typedef logic [3:1] rsc_state_t;

  function automatic logic rsc_tap(input logic [3:0] g, input rsc_state_t s);
    return ^(g[3:1] & s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/turbo_stream_receiver_rsc_trellis_checker.sv
`default_nettype none
// ============================================================================
// Module      : rsc_trellis_checker
// Description : Constituent-1 RSC trellis replica giving the expected parity
//               bit and a preview of the six termination bits.
// Revision    : 1.0 - initial release
// ============================================================================
module rsc_trellis_checker
  import turbo_stream_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  input  logic       u,
  output logic       z_exp,
  output logic [5:0] tail_bits
);

  rsc_state_t state_q;
  rsc_state_t state_d;
  rsc_state_t state_cur;
  rsc_state_t tail_s;
  logic       a;

  // clear lets the first bit of a block be processed from the zero state
  always_comb begin
    state_cur = clear ? '0 : state_q;
    a         = u ^ rsc_tap(RSC_G0, state_cur);
    z_exp     = a ^ rsc_tap(RSC_G1, state_cur);
    state_d   = state_q;
    if (step) begin
      state_d = {state_cur[2:1], a};
    end else if (clear) begin
      state_d = '0;
    end
  end

  // Termination input cancels the feedback, so a = 0 on every tail step.
  always_comb begin
    tail_s    = state_q;
    tail_bits = '0;
    for (int i = 0; i < 3; i++) begin
      tail_bits[2*i]   = rsc_tap(RSC_G0, tail_s);
      tail_bits[2*i+1] = rsc_tap(RSC_G1, tail_s);
      tail_s           = {tail_s[2:1], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/turbo_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : turbo_stream_receiver
// Description : Deframes turbo encoder output into bytes, checks parity-1 and
//               the encoder-1 tail, and reports per-block status.
// Revision    : 1.0 - initial release
// ============================================================================
module turbo_stream_receiver
  import turbo_stream_receiver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             look_now,
  input  logic             xk,
  input  logic             zk,
  input  logic             zkp,
  input  logic             length_in,
  output logic [7:0]       sys_byte,
  output logic [7:0]       par1_byte,
  output logic [7:0]       par2_byte,
  output logic             byte_valid,
  output logic             blk_done,
  output logic             blk_long,
  output logic [CNT_W-1:0] parity_err_cnt,
  output logic             tail_err,
  output logic             frame_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_LONG  = CNT_W'(K_LONG - 1);
  localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(K_SHORT - 1);
  localparam logic [CNT_W-1:0] ERR_MAX    = '1;
  localparam logic [1:0]       LAST_TAIL  = 2'(TAIL_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       t_q, t_d;
  logic [7:0]       sh_x_q, sh_x_d;
  logic [7:0]       sh_z_q, sh_z_d;
  logic [7:0]       sh_p_q, sh_p_d;
  logic [7:0]       sys_byte_q, sys_byte_d;
  logic [7:0]       par1_byte_q, par1_byte_d;
  logic [7:0]       par2_byte_q, par2_byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             blk_done_q, blk_done_d;
  logic             blk_long_q, blk_long_d;
  logic [CNT_W-1:0] perr_q, perr_d;
  logic             tail_err_q, tail_err_d;
  logic             frame_err_q, frame_err_d;

  logic             trellis_clear;
  logic             trellis_step;
  logic             z_exp;
  logic [5:0]       tail_bits;
  logic             bit_take;
  logic [2:0]       pos;
  logic [CNT_W-1:0] last_bit;

  rsc_trellis_checker u_trellis (
    .clk       (clk),
    .rst       (rst),
    .clear     (trellis_clear),
    .step      (trellis_step),
    .u         (xk),
    .z_exp     (z_exp),
    .tail_bits (tail_bits)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    t_d           = t_q;
    sh_x_d        = sh_x_q;
    sh_z_d        = sh_z_q;
    sh_p_d        = sh_p_q;
    sys_byte_d    = sys_byte_q;
    par1_byte_d   = par1_byte_q;
    par2_byte_d   = par2_byte_q;
    byte_valid_d  = 1'b0;
    blk_done_d    = 1'b0;
    blk_long_d    = blk_long_q;
    perr_d        = perr_q;
    tail_err_d    = tail_err_q;
    frame_err_d   = frame_err_q;
    trellis_clear = 1'b0;
    trellis_step  = 1'b0;
    bit_take      = 1'b0;
    pos           = (state_q == ST_IDLE) ? 3'd0 : cnt_q[2:0];
    last_bit      = blk_long_q ? LAST_LONG : LAST_SHORT;

    case (state_q)
      ST_IDLE: begin
        if (look_now) begin
          trellis_clear = 1'b1;
          trellis_step  = 1'b1;
          bit_take      = 1'b1;
          blk_long_d    = length_in;
          perr_d        = {{(CNT_W-1){1'b0}}, zk ^ z_exp};
          tail_err_d    = 1'b0;
          frame_err_d   = 1'b0;
          cnt_d         = {{(CNT_W-1){1'b0}}, 1'b1};
          state_d       = ST_DATA;
        end
      end
      ST_DATA: begin
        if (look_now) begin
          trellis_step = 1'b1;
          bit_take     = 1'b1;
          if ((zk != z_exp) && (perr_q != ERR_MAX)) begin
            perr_d = perr_q + 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_bit) begin
            t_d     = 2'd0;
            state_d = ST_TAIL;
          end
        end else begin
          frame_err_d = 1'b1;
          blk_done_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_TAIL: begin
        if (look_now) begin
          // t=2,3 carry the encoder-2 tail, which this block cannot check
          if ((t_q == 2'd0) && ({zkp, zk, xk} != tail_bits[2:0])) begin
            tail_err_d = 1'b1;
          end
          if ((t_q == 2'd1) && ({zkp, zk, xk} != tail_bits[5:3])) begin
            tail_err_d = 1'b1;
          end
          t_d = t_q + 1'b1;
          if (t_q == LAST_TAIL) begin
            blk_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          frame_err_d = 1'b1;
          blk_done_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bit_take) begin
      sh_x_d[pos] = xk;
      sh_z_d[pos] = zk;
      sh_p_d[pos] = zkp;
      if (pos == 3'd7) begin
        sys_byte_d   = sh_x_d;
        par1_byte_d  = sh_z_d;
        par2_byte_d  = sh_p_d;
        byte_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      t_q          <= '0;
      sh_x_q       <= '0;
      sh_z_q       <= '0;
      sh_p_q       <= '0;
      sys_byte_q   <= '0;
      par1_byte_q  <= '0;
      par2_byte_q  <= '0;
      byte_valid_q <= 1'b0;
      blk_done_q   <= 1'b0;
      blk_long_q   <= 1'b0;
      perr_q       <= '0;
      tail_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      t_q          <= t_d;
      sh_x_q       <= sh_x_d;
      sh_z_q       <= sh_z_d;
      sh_p_q       <= sh_p_d;
      sys_byte_q   <= sys_byte_d;
      par1_byte_q  <= par1_byte_d;
      par2_byte_q  <= par2_byte_d;
      byte_valid_q <= byte_valid_d;
      blk_done_q   <= blk_done_d;
      blk_long_q   <= blk_long_d;
      perr_q       <= perr_d;
      tail_err_q   <= tail_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign sys_byte       = sys_byte_q;
  assign par1_byte      = par1_byte_q;
  assign par2_byte      = par2_byte_q;
  assign byte_valid     = byte_valid_q;
  assign blk_done       = blk_done_q;
  assign blk_long       = blk_long_q;
  assign parity_err_cnt = perr_q;
  assign tail_err       = tail_err_q;
  assign frame_err      = frame_err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/turbo_stream_receiver.md
Name: turbo_stream_receiver

Overview:
Receive-side deframer and checker for the serialized turbo encoder output stream (xk/zk/zkp triplets qualified by look_now, plus the length flag).
- Captures one code block of K data cycles followed by 4 trellis-termination cycles.
- Packs the systematic and both parity streams into bytes.
- Re-runs the constituent-1 RSC trellis on received xk to check every zk bit and the encoder-1 tail bits.
- Reports per-block status. Sits at the downstream end of the encoder link, in loopback test benches and ahead of a future decoder.

Parameters:
K_LONG, 6144, data cycles per block when length flag = 1
K_SHORT, 1056, data cycles per block when length flag = 0
TAIL_CYCLES, 4, termination cycles following the data cycles
CNT_W, 13, width of the bit counter and the error counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous and active-low
look_now  in  1  stream valid; xk/zk/zkp/length_in are sampled when 1
xk  in  1  systematic bit (data cycles) / tail field d0
zk  in  1  parity-1 bit / tail field d1
zkp  in  1  parity-2 bit / tail field d2
length_in  in  1  block length flag (1 = K_LONG), sampled on first data cycle only
sys_byte  out  8  packed systematic bits, bit0 = earliest
par1_byte  out  8  packed zk bits
par2_byte  out  8  packed zkp bits
byte_valid  out  1  one-cycle pulse, the three bytes are valid
blk_done  out  1  one-cycle pulse at block end (normal or aborted)
blk_long  out  1  length flag latched for the current/last block
parity_err_cnt  out  CNT_W  zk mismatches in the last block, saturating
tail_err  out  1  encoder-1 tail mismatch in the last block
frame_err  out  1  last block aborted by look_now dropping early
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE. Trellis state, counters and shifters cleared. All outputs 0.
- State IDLE, look_now=1 at an edge:
  - Sample = data bit 0. Latch blk_long <= length_in; K = blk_long ? K_LONG : K_SHORT.
  - Clear parity_err_cnt, tail_err and frame_err.
  - Trellis (s1,s2,s3) starts at 000; process bit 0.
  - cnt <= 1, go DATA.
- Trellis step (LTE RSC, g0=1+D^2+D^3, g1=1+D+D^3), input u = xk:
  - a = u^s2^s3; expected z = a^s1^s3.
  - Update: s3<=s2, s2<=s1, s1<=a.
  - If zk != expected z: parity_err_cnt += 1, saturating at 2^CNT_W-1.
- State DATA, each edge with look_now=1:
  - Trellis step. Shift xk/zk/zkp into the byte shifters at bit position cnt[2:0].
  - On the 8th bit, pulse byte_valid next cycle. K is a multiple of 8, so there are no partial bytes.
  - cnt == K-1 (after processing): go TAIL, t=0.
- State DATA, look_now=0: frame_err=1, pulse blk_done, go IDLE. Partially filled bytes are discarded.
- Entry to TAIL: compute the expected encoder-1 termination bits from the current state. Each step uses u = s2^s3 (so a=0) and z = s1^s3, then shifts; three steps give x0,z0,x1,z1,x2,z2.
- TAIL field checks:
  - t=0: d0=x0, d1=z0, d2=x1.
  - t=1: d0=z1, d1=x2, d2=z2.
  - t=2,3 carry the encoder-2 tail and are not checked.
  - Any mismatch sets tail_err.
- TAIL, look_now=0 before t=3 has been captured: frame_err=1, blk_done, IDLE.
- After t=3 is captured: blk_done pulses in the next cycle, then go IDLE.
- Back-to-back blocks: look_now may stay 1 straight from the last tail cycle into the next block.
  - IDLE must accept it in the very cycle blk_done is high. No gap cycle.
  - Status outputs of the finished block hold until the next block's first data edge.
- Latency: byte_valid one cycle after the edge capturing the 8th bit. blk_done one cycle after the final tail or abort edge.
- Status outputs are registered. blk_done and byte_valid are never high for more than one cycle.
- Reset mid-block: immediate return to IDLE, no blk_done.

Decomposition:
- Shared package: K_LONG/K_SHORT/TAIL_CYCLES constants, FSM state encoding (IDLE, DATA, TAIL), and the RSC generator polynomials.
- Sub-module rsc_trellis_checker: 3-bit state with step/clear/terminate-preview. Outputs expected z and the 6 tail bits.
- The byte packer and FSM live in the top module.

Test Plan:
- Short block, all-zero data and tails, look_now continuous 1060 cycles -> 132 byte_valid pulses with all bytes 0x00; blk_done once; blk_long=0; parity_err_cnt=0; tail_err=0.
- Short block, xk=1,0,0,0,..., zk=1,1,1 at bits 0..2 then correct encoder values -> parity_err_cnt=0, first sys_byte=0x01, first par1_byte bits[2:0]=111.
- Same block with zk bit 5 flipped -> parity_err_cnt=1. Separately flip tail t=1 d2 -> tail_err=1 and parity_err_cnt=0.
- Long block with look_now dropped at data bit 500 -> blk_done after the drop, frame_err=1, 62 byte_valid pulses only, busy=0.
- Long block immediately followed by a short block, no gap -> two blk_done pulses 6148 and 1060 cycles apart; blk_long reads 1 then 0.
- rst=0 asserted at data bit 300 -> all outputs 0 asynchronously, no blk_done. The next block decodes cleanly with 0 errors.
